response_hex_formatter: RTL and testbench
=========================================

Name: response_hex_formatter

Overview:
- Downstream stage of the command state machines.
- Consumes the ResponsePending / ResponseBytes / ResponseByteCount bundle and serialises it as an ASCII hex line: two uppercase hex digits per byte, a space between bytes, CR LF at the end.
- Output goes to the UART TX byte interface through a valid/ready handshake.
- Acknowledges each response so the command state machines can clear ResponsePending.

Parameters:
- MAX_BYTES, 4, number of response byte slots; larger counts are clamped to this.
- SEP_CHAR, 8'h20, separator emitted between bytes.
- UPPER_HEX, 1, 1 selects 'A'-'F', 0 selects 'a'-'f'.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- response_pending  in  1  level; a response is available
- response_bytes  in  8*MAX_BYTES  flattened ResponseBytes; slot 0 is in bits [7:0]
- response_byte_count  in  4  number of valid slots (0..15; clamped)
- response_ack  out  1  one-cycle pulse when the response is latched
- tx_data  out  8  ASCII character to UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts tx_data on this edge
- busy  out  1  high from latch until the last character is accepted

Behaviour:
- Reset (async, immediate):
  - state=IDLE, tx_valid=0, tx_data=8'h00, response_ack=0, busy=0.
  - Byte buffer and index are cleared.
- Latch:
  - In IDLE with response_pending=1, at the clock edge: copy response_bytes into the internal buffer.
  - Compute count = min(response_byte_count, MAX_BYTES).
  - Set index=0, pulse response_ack for exactly 1 cycle, set busy=1.
- Latency: the first character appears with tx_valid=1 on the cycle after the latch edge.
- Handshake:
  - A transfer occurs on an edge where tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid are held stable until that transfer.
  - tx_valid never drops without a transfer.
  - Back-to-back transfers are allowed: the next character is presented in the cycle after a transfer, so throughput is 1 character per cycle while tx_ready stays high.
- States: IDLE, HI_NIB, LO_NIB, SEP, CR, LF.
  - IDLE -> HI_NIB on latch when count>0.
  - IDLE -> CR on latch when count=0.
  - HI_NIB emits buf[index][7:4] as hex; -> LO_NIB on transfer.
  - LO_NIB emits buf[index][3:0] as hex; on transfer -> SEP if index<count-1, else -> CR.
  - SEP emits SEP_CHAR; on transfer, index+1 and -> HI_NIB.
  - CR emits 8'h0D; -> LF on transfer.
  - LF emits 8'h0A; on transfer -> IDLE, busy=0, tx_valid=0 on the next cycle.
- Character count per response: 3*count+1 for count>=1 (including CR LF); 2 for count=0.
- Nibble mapping: 0-9 -> 8'h30-8'h39; 10-15 -> 8'h41-8'h46 (8'h61-8'h66 when UPPER_HEX=0).
- response_pending while busy:
  - Ignored; the latched buffer is not disturbed by input changes.
  - If the level is still high on return to IDLE, it is latched as a new response, one IDLE cycle minimum.
- Upstream must drop response_pending within 1 cycle of response_ack. A level held high produces a repeat transmission after each IDLE cycle, which is the defined behaviour.
- index width is clog2(MAX_BYTES) bits and never wraps, because count is clamped.
- Reset mid-line: output stops at once and the partial line is discarded. No ack is issued for the discarded response.

Decomposition:
- Shared package resp_fmt_pkg:
  - resp_fmt_state_t enum.
  - ASCII constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_SPACE=8'h20, ASCII_0=8'h30, ASCII_A=8'h41.
- One natural sub-module: nibble_to_ascii, combinational 4-bit to 8-bit with an UPPER_HEX parameter. It is instantiated once and muxed by state.

Test Plan:
- Count 4, bytes AA,AB,AC,AD, tx_ready=1 -> 13 chars "AA AB AC AD\r\n"; response_ack one cycle at latch; first tx_valid the next cycle; busy drops after LF.
- Count 1, byte 0x0F -> 8'h30,8'h46,8'h0D,8'h0A; count 0 -> 8'h0D,8'h0A only; count 7 -> clamped to 4, 13 chars.
- Backpressure: tx_ready low for 5 cycles while the second char is presented -> tx_data=8'h41 and tx_valid=1 stay stable; no char lost or duplicated.
- response_pending held high across a whole line -> exactly one ack during the line; response_bytes changed mid-line do not alter output; a second line starts after IDLE.
- Reset asserted mid-SEP, asynchronously between edges -> tx_valid=0 and busy=0 immediately; after release with pending=1 the full line restarts from the first hex digit.
- UPPER_HEX=0, byte 0xBE -> 8'h62,8'h65,8'h0D,8'h0A.

Source files
------------

// File: rtl/response_hex_formatter_pkg.sv
// Shared types and ASCII constants for the response hex formatter.
package resp_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI_NIB = 3'd1,
        ST_LO_NIB = 3'd2,
        ST_SEP    = 3'd3,
        ST_CR     = 3'd4,
        ST_LF     = 3'd5
    } resp_fmt_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_A_LC  = 8'h61;

endpackage

// File: rtl/response_hex_formatter_if.sv
// Response bundle in, ASCII byte stream out. tx_data/tx_valid are held until a
// transfer (tx_valid & tx_ready at a clock edge); tx_valid never drops without one.
interface response_hex_formatter_if #(
    parameter int MAX_BYTES = 4
);
    import resp_fmt_pkg::*;

    logic                   response_pending;
    logic [8*MAX_BYTES-1:0] response_bytes;
    logic [3:0]             response_byte_count;
    logic                   response_ack;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    resp_fmt_state_t        dbg_state;

    modport master (
        output response_pending, response_bytes, response_byte_count, tx_ready,
        input  response_ack, tx_data, tx_valid, busy, dbg_state
    );

    modport slave (
        input  response_pending, response_bytes, response_byte_count, tx_ready,
        output response_ack, tx_data, tx_valid, busy, dbg_state
    );

endinterface

// File: rtl/response_hex_formatter_nibble_to_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit.
module nibble_to_ascii
    import resp_fmt_pkg::*;
#(
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] ALPHA_BASE = UPPER_HEX ? ASCII_A : ASCII_A_LC;

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'h0, nibble_i};
        end else begin
            ascii_o = ALPHA_BASE + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/response_hex_formatter.sv
// Serialises a latched response as "HH HH .. HH\r\n" onto a valid/ready byte stream.
module response_hex_formatter
    import resp_fmt_pkg::*;
#(
    parameter int         MAX_BYTES = 4,
    parameter logic [7:0] SEP_CHAR  = ASCII_SPACE,
    parameter bit         UPPER_HEX = 1'b1
) (
    input logic                     clock,
    input logic                     reset,
    response_hex_formatter_if.slave bus
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    resp_fmt_state_t  state_q, state_d;
    logic [7:0]       buf_q [MAX_BYTES];
    logic [7:0]       buf_d [MAX_BYTES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ack_q, ack_d;

    logic             tx_valid;
    logic             tx_fire;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] clamped_count;
    logic             last_byte;
    logic [3:0]       nibble;
    logic [7:0]       nibble_ascii;

    // Counts above MAX_BYTES are clamped so idx_q can never run past the buffer.
    assign clamped_count = (32'(bus.response_byte_count) > MAX_BYTES)
                           ? CNT_W'(MAX_BYTES) : CNT_W'(bus.response_byte_count);
    assign last_byte     = (CNT_W'(idx_q) + CNT_W'(1)) >= count_q;
    assign tx_valid      = (state_q != ST_IDLE);
    assign tx_fire       = tx_valid && bus.tx_ready;
    assign nibble        = (state_q == ST_HI_NIB) ? buf_q[idx_q][7:4] : buf_q[idx_q][3:0];

    nibble_to_ascii #(.UPPER_HEX(UPPER_HEX)) u_nibble (
        .nibble_i (nibble),
        .ascii_o  (nibble_ascii)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.response_pending) begin
                    for (int i = 0; i < MAX_BYTES; i++) buf_d[i] = bus.response_bytes[8*i +: 8];
                    count_d = clamped_count;
                    idx_d   = '0;
                    ack_d   = 1'b1;
                    state_d = (clamped_count != '0) ? ST_HI_NIB : ST_CR;
                end
            end
            ST_HI_NIB: if (tx_fire) state_d = ST_LO_NIB;
            ST_LO_NIB: if (tx_fire) state_d = last_byte ? ST_CR : ST_SEP;
            ST_SEP: begin
                if (tx_fire) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_HI_NIB;
                end
            end
            ST_CR:   if (tx_fire) state_d = ST_LF;
            ST_LF:   if (tx_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            ST_HI_NIB, ST_LO_NIB: tx_data = nibble_ascii;
            ST_SEP:               tx_data = SEP_CHAR;
            ST_CR:                tx_data = ASCII_CR;
            ST_LF:                tx_data = ASCII_LF;
            default:              tx_data = 8'h00;
        endcase
    end

    assign bus.tx_data      = tx_data;
    assign bus.tx_valid     = tx_valid;
    assign bus.busy         = tx_valid;
    assign bus.response_ack = ack_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_response_hex_formatter.sv
// Randomised and directed bench for response_hex_formatter against a string-based line model.
module tb_response_hex_formatter;
  import resp_fmt_pkg::*;

  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  response_hex_formatter_if #(.MAX_BYTES(MB)) bus ();
  response_hex_formatter_if #(.MAX_BYTES(MB)) bus_lc ();

  response_hex_formatter #(.MAX_BYTES(MB)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  response_hex_formatter #(.MAX_BYTES(MB), .UPPER_HEX(1'b0)) u_dut_lc (
    .clock (clock),
    .reset (reset),
    .bus   (bus_lc)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_lc_q[$];
  int         ack_total = 0;
  int         chars_seen = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the text line a response should produce.
  function automatic void push_line(input bit lc, input logic [31:0] bytes, input int cnt);
    string      digits;
    int         n;
    logic [7:0] b;
    logic [7:0] line[$];
    digits = lc ? "0123456789abcdef" : "0123456789ABCDEF";
    n = (cnt > MB) ? MB : cnt;
    for (int i = 0; i < n; i++) begin
      b = bytes[8*i +: 8];
      line.push_back(digits[b[7:4]]);
      line.push_back(digits[b[3:0]]);
      if (i < n - 1) line.push_back(8'h20);
    end
    line.push_back(8'h0D);
    line.push_back(8'h0A);
    foreach (line[k]) begin
      if (lc) exp_lc_q.push_back(line[k]);
      else exp_q.push_back(line[k]);
    end
  endfunction

  // Monitor: inputs only change just after posedge, so negedge values decide the next edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.response_ack) ack_total++;
      if (hold_pend) begin
        check_eq("hold_valid", bus.tx_valid, 1);
        check_eq("hold_data", bus.tx_data, hold_data);
      end
      hold_pend = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        chars_seen++;
        check_eq("char_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("tx_char", bus.tx_data, exp_q.pop_front());
      end
      if (bus_lc.tx_valid && bus_lc.tx_ready) begin
        check_eq("lc_char_expected", exp_lc_q.size() != 0, 1);
        if (exp_lc_q.size() != 0) check_eq("lc_tx_char", bus_lc.tx_data, exp_lc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_line(input logic [31:0] b, input logic [3:0] cnt, input bit hold);
    bus.response_pending    = 1'b1;
    bus.response_bytes      = b;
    bus.response_byte_count = cnt;
    push_line(1'b0, b, int'(cnt));
    tick();
    check_eq("ack_at_latch", bus.response_ack, 1);
    check_eq("valid_after_latch", bus.tx_valid, 1);
    check_eq("busy_after_latch", bus.busy, 1);
    if (!hold) bus.response_pending = 1'b0;
  endtask

  task automatic run_until_idle(input bit rand_ready, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      if (rand_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check_eq("idle_reached", bus.busy, 0);
    bus.tx_ready = 1'b1;
  endtask

  task automatic full_line(input string tag, input logic [31:0] b, input logic [3:0] cnt,
                           input int exp_chars);
    int c0 = chars_seen;
    start_line(b, cnt, 1'b0);
    run_until_idle(1'b0, 100);
    check_eq({tag, "_chars"}, chars_seen - c0, exp_chars);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         a0;
    int         c0;
    logic [31:0] b1;
    logic [31:0] b2;
    int         n;

    reset = 1'b1;
    bus.response_pending = 1'b0;
    bus.response_bytes = '0;
    bus.response_byte_count = '0;
    bus.tx_ready = 1'b1;
    bus_lc.response_pending = 1'b0;
    bus_lc.response_bytes = '0;
    bus_lc.response_byte_count = '0;
    bus_lc.tx_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 8'h00);
    check_eq("rst_ack", bus.response_ack, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();

    // Four bytes, ready always high.
    a0 = ack_total;
    c0 = chars_seen;
    start_line(32'hADACABAA, 4'd4, 1'b0);
    tick();
    check_eq("ack_one_cycle", bus.response_ack, 0);
    run_until_idle(1'b0, 100);
    check_eq("cnt4_chars", chars_seen - c0, 13);
    check_eq("cnt4_valid_low", bus.tx_valid, 0);
    check_eq("cnt4_acks", ack_total - a0, 1);
    check_eq("cnt4_drained", exp_q.size(), 0);

    full_line("cnt1", 32'h0000000F, 4'd1, 4);
    full_line("cnt0", 32'h12345678, 4'd0, 2);
    full_line("cnt7", 32'hDEADBEEF, 4'd7, 13);
    full_line("cnt15", 32'h01234567, 4'd15, 13);

    // Backpressure on the second character ('A' of "1A").
    c0 = chars_seen;
    start_line(32'h0000001A, 4'd1, 1'b0);
    tick();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_data", bus.tx_data, 8'h41);
      check_eq("bp_valid", bus.tx_valid, 1);
      tick();
    end
    bus.tx_ready = 1'b1;
    run_until_idle(1'b0, 100);
    check_eq("bp_chars", chars_seen - c0, 4);
    check_eq("bp_drained", exp_q.size(), 0);

    // Pending held high through a line; bytes changed mid-line.
    a0 = ack_total;
    b1 = $urandom;
    b2 = $urandom;
    start_line(b1, 4'd4, 1'b1);
    tick();
    bus.response_bytes = b2;
    push_line(1'b0, b2, 4);
    run_until_idle(1'b0, 100);
    check_eq("held_acks_in_line", ack_total - a0, 1);
    tick();
    check_eq("relatch_ack", bus.response_ack, 1);
    bus.response_pending = 1'b0;
    run_until_idle(1'b0, 100);
    check_eq("held_drained", exp_q.size(), 0);

    // Asynchronous reset while the separator is presented.
    a0 = ack_total;
    b1 = $urandom;
    start_line(b1, 4'd2, 1'b1);
    tick();
    tick();
    check_eq("pre_rst_state", bus.dbg_state, ST_SEP);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", bus.tx_valid, 0);
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_data", bus.tx_data, 8'h00);
    exp_q.delete();
    push_line(1'b0, b1, 2);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check_eq("restart_ack", bus.response_ack, 1);
    check_eq("restart_data", bus.tx_data, {24'h0, push_probe(b1)});
    bus.response_pending = 1'b0;
    run_until_idle(1'b0, 100);
    check_eq("restart_acks", ack_total - a0, 2);
    check_eq("restart_drained", exp_q.size(), 0);

    // Lowercase instance.
    bus_lc.response_pending = 1'b1;
    bus_lc.response_bytes = 32'h000000BE;
    bus_lc.response_byte_count = 4'd1;
    push_line(1'b1, 32'h000000BE, 1);
    tick();
    check_eq("lc_ack", bus_lc.response_ack, 1);
    bus_lc.response_pending = 1'b0;
    n = 0;
    while (bus_lc.busy && n < 100) begin
      tick();
      n++;
    end
    check_eq("lc_idle", bus_lc.busy, 0);
    check_eq("lc_drained", exp_lc_q.size(), 0);

    // Randomised responses with random backpressure.
    for (int r = 0; r < 30; r++) begin
      b1 = $urandom;
      start_line(b1, 4'($urandom_range(0, 15)), 1'b0);
      run_until_idle(1'b1, 500);
      check_eq("rand_drained", exp_q.size(), 0);
      if ($urandom_range(0, 1) != 0) tick();
    end

    check_eq("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // First character of a restarted line: high nibble of slot 0.
  function automatic logic [7:0] push_probe(input logic [31:0] b);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[b[7:4]];
  endfunction

endmodule
